// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared types and constants for the SPI transaction sequencer.
//   state_t : sequencer FSM states
//   cmd_t   : queued command {slave, mode, data}
//   SS_*    : slave-select encodings (SS_NONE is the invalid select)
//   ERR_DATA: response byte returned on timeout or invalid select
package spi_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        RESP
    } state_t;

    typedef struct packed {
        logic [1:0] slave;
        logic [1:0] mode;
        logic [7:0] data;
    } cmd_t;

    localparam logic [1:0] SS_NONE  = 2'b00;
    localparam logic [1:0] SS_I     = 2'b01;
    localparam logic [1:0] SS_II    = 2'b10;
    localparam logic [1:0] SS_III   = 2'b11;
    localparam logic [7:0] ERR_DATA = 8'hFF;

endpackage

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: command FIFO with show-ahead read data.
//   Clock, Reset   : clock, synchronous active-high reset (flushes pointers)
//   push, wr_data  : write a command (ignored when full)
//   pop            : consume the head entry (ignored when empty)
//   rd_data        : head entry, valid whenever !empty
//   full, empty    : occupancy flags
// DEPTH must be a power of two, >= 2, so the pointers wrap naturally.
module spi_cmd_fifo
    import spi_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic push,
    input  cmd_t wr_data,
    input  logic pop,
    output cmd_t rd_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the flushed pointers make stale entries unreachable.
    always_ff @(posedge Clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/spi_transaction_sequencer.sv
// spi_transaction_sequencer: queues byte transfers and drives the SPI master
// load/enable/done handshake, returning each received byte as a response.
//   Clock, Reset        : clock, synchronous active-high reset
//   Cmd_*               : valid/ready command port {slave, mode, data}
//   Rsp_*               : valid/ready response port {data, slave, error}
//   Busy                : FSM not idle or commands queued
//   Spi_*               : registered controls to / inputs from the SPI interface
// Optional build macro SPI_SEQ_STATS_EN adds Stat_Xfers / Stat_Errors
// (saturating counts of accepted responses and of error responses).
module spi_transaction_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Cmd_Valid,
    output logic       Cmd_Ready,
    input  logic [1:0] Cmd_Slave,
    input  logic [1:0] Cmd_Mode,
    input  logic [7:0] Cmd_Data,
    output logic       Rsp_Valid,
    input  logic       Rsp_Ready,
    output logic [7:0] Rsp_Data,
    output logic [1:0] Rsp_Slave,
    output logic       Rsp_Error,
    output logic       Busy,
    output logic       Spi_Master_Reset,
    output logic       Spi_Load,
    output logic       Spi_Enable,
    output logic [1:0] Spi_Mode,
    output logic [1:0] Spi_Slave_Select,
    output logic [7:0] Spi_Tx_Data,
    input  logic       Spi_Done,
    input  logic [7:0] Spi_Rx_Data
`ifdef SPI_SEQ_STATS_EN
    ,
    output logic [15:0] Stat_Xfers,
    output logic [15:0] Stat_Errors
`endif
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t        state;
    state_t        state_nxt;
    cmd_t          cmd_in;
    cmd_t          head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [TW-1:0] tcnt;
    logic          done_prev;
    logic          done_rise;
    logic          timeout_hit;
    logic          rst_d;

    assign cmd_in = '{slave: Cmd_Slave, mode: Cmd_Mode, data: Cmd_Data};

    spi_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clock   (Clock),
        .Reset   (Reset),
        .push    (Cmd_Valid),
        .wr_data (cmd_in),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign Cmd_Ready   = ~fifo_full;
    assign Busy        = (state != IDLE) | ~fifo_empty;
    assign fifo_pop    = (state == IDLE) & ~fifo_empty & ~Rsp_Valid;
    // Only a fresh 0->1 transition completes; a level left over from the
    // previous transfer is ignored.
    assign done_rise   = Spi_Done & ~done_prev;
    assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (fifo_pop) state_nxt = (head.slave == SS_NONE) ? RESP : LOAD;
            LOAD:      state_nxt = WAIT_DONE;
            WAIT_DONE: if (done_rise || timeout_hit) state_nxt = RESP;
            RESP:      if (Rsp_Ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Registered outputs and datapath.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            tcnt             <= '0;
            done_prev        <= 1'b0;
            rst_d            <= 1'b1;
            Spi_Master_Reset <= 1'b1;
            Spi_Load         <= 1'b0;
            Spi_Enable       <= 1'b0;
            Spi_Mode         <= '0;
            Spi_Slave_Select <= '0;
            Spi_Tx_Data      <= '0;
            Rsp_Valid        <= 1'b0;
            Rsp_Data         <= '0;
            Rsp_Slave        <= '0;
            Rsp_Error        <= 1'b0;
        end else begin
            done_prev  <= Spi_Done;
            // rst_d stretches the master reset one cycle past the last reset edge;
            // a timeout (without a simultaneous completion) also pulses it.
            rst_d            <= 1'b0;
            Spi_Master_Reset <= rst_d | ((state == WAIT_DONE) & timeout_hit & ~done_rise);
            Spi_Load         <= (state_nxt == LOAD);
            Spi_Enable       <= (state_nxt == WAIT_DONE);
            Rsp_Valid        <= (state_nxt == RESP);

            if (state == LOAD)           tcnt <= '0;
            else if (state == WAIT_DONE) tcnt <= tcnt + 1'b1;

            if (fifo_pop) begin
                Rsp_Slave <= head.slave;
                if (head.slave == SS_NONE) begin
                    Rsp_Error <= 1'b1;
                    Rsp_Data  <= ERR_DATA;
                end else begin
                    Spi_Slave_Select <= head.slave;
                    Spi_Mode         <= head.mode;
                    Spi_Tx_Data      <= head.data;
                end
            end

            if (state == WAIT_DONE) begin
                if (done_rise) begin
                    Rsp_Data  <= Spi_Rx_Data;
                    Rsp_Error <= 1'b0;
                end else if (timeout_hit) begin
                    Rsp_Data  <= ERR_DATA;
                    Rsp_Error <= 1'b1;
                end
            end
        end
    end

`ifdef SPI_SEQ_STATS_EN
    logic rsp_hs;
    assign rsp_hs = (state == RESP) & Rsp_Valid & Rsp_Ready;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Stat_Xfers  <= '0;
            Stat_Errors <= '0;
        end else if (rsp_hs) begin
            if (Stat_Xfers != 16'hFFFF) Stat_Xfers <= Stat_Xfers + 1'b1;
            if (Rsp_Error && Stat_Errors != 16'hFFFF) Stat_Errors <= Stat_Errors + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Testbench for spi_transaction_sequencer. A done stub answers each enabled
// transfer 10 cycles in with rx = tx ^ 8'h99; expected responses are queued
// when commands are accepted and compared when the DUT presents them.
// Build with SPI_SEQ_STATS_EN to also exercise the statistics counters.
module tb_spi_transaction_sequencer;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] slave;
        logic       err;
    } rsp_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Cmd_Valid = 1'b0;
    logic       Cmd_Ready;
    logic [1:0] Cmd_Slave = '0;
    logic [1:0] Cmd_Mode = '0;
    logic [7:0] Cmd_Data = '0;
    logic       Rsp_Valid;
    logic       Rsp_Ready = 1'b0;
    logic [7:0] Rsp_Data;
    logic [1:0] Rsp_Slave;
    logic       Rsp_Error;
    logic       Busy;
    logic       Spi_Master_Reset;
    logic       Spi_Load;
    logic       Spi_Enable;
    logic [1:0] Spi_Mode;
    logic [1:0] Spi_Slave_Select;
    logic [7:0] Spi_Tx_Data;
    logic       Spi_Done;
    logic [7:0] Spi_Rx_Data;
`ifdef SPI_SEQ_STATS_EN
    logic [15:0] Stat_Xfers;
    logic [15:0] Stat_Errors;
`endif

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];

    bit         stub_en = 1'b1;
    logic       stub_done = 1'b0;
    logic [7:0] stub_rx = '0;
    int         stub_cnt = 0;
    logic       man_done = 1'b0;
    logic [7:0] man_rx = '0;

    assign Spi_Done    = stub_en ? stub_done : man_done;
    assign Spi_Rx_Data = stub_en ? stub_rx : man_rx;

    always #5 Clock = ~Clock;

    spi_transaction_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .Cmd_Valid        (Cmd_Valid),
        .Cmd_Ready        (Cmd_Ready),
        .Cmd_Slave        (Cmd_Slave),
        .Cmd_Mode         (Cmd_Mode),
        .Cmd_Data         (Cmd_Data),
        .Rsp_Valid        (Rsp_Valid),
        .Rsp_Ready        (Rsp_Ready),
        .Rsp_Data         (Rsp_Data),
        .Rsp_Slave        (Rsp_Slave),
        .Rsp_Error        (Rsp_Error),
        .Busy             (Busy),
        .Spi_Master_Reset (Spi_Master_Reset),
        .Spi_Load         (Spi_Load),
        .Spi_Enable       (Spi_Enable),
        .Spi_Mode         (Spi_Mode),
        .Spi_Slave_Select (Spi_Slave_Select),
        .Spi_Tx_Data      (Spi_Tx_Data),
        .Spi_Done         (Spi_Done),
        .Spi_Rx_Data      (Spi_Rx_Data)
`ifdef SPI_SEQ_STATS_EN
        ,
        .Stat_Xfers       (Stat_Xfers),
        .Stat_Errors      (Stat_Errors)
`endif
    );

    // Done stub: raises done on the 10th enabled cycle, drops it with Enable.
    always @(negedge Clock) begin
        if (!Spi_Enable) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
        end else begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == 9) begin
                stub_done <= 1'b1;
                stub_rx   <= Spi_Tx_Data ^ 8'h99;
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [1:0] s, input logic [1:0] m,
                        input logic [7:0] d, input rsp_t e);
        Cmd_Valid = 1'b1;
        Cmd_Slave = s;
        Cmd_Mode  = m;
        Cmd_Data  = d;
        for (int i = 0; i < 100 && Cmd_Ready !== 1'b1; i++) @(negedge Clock);
        @(negedge Clock);
        exp_q.push_back(e);
        Cmd_Valid = 1'b0;
    endtask

    // Waits for Rsp_Valid, tallying control strobes seen on the way.
    task automatic wait_rsp(input int budget, output bit ok,
                            output int loads, output int ens, output int mrs);
        ok = 1'b0; loads = 0; ens = 0; mrs = 0;
        for (int i = 0; i < budget; i++) begin
            loads += int'(Spi_Load);
            ens   += int'(Spi_Enable);
            mrs   += int'(Spi_Master_Reset);
            if (Rsp_Valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clock);
        end
    endtask

    function automatic rsp_t next_exp();
        if (exp_q.size() == 0) return '{data: 8'h00, slave: 2'b00, err: 1'bx};
        return exp_q.pop_front();
    endfunction

    task automatic accept();
        Rsp_Ready = 1'b1;
        @(negedge Clock);
        Rsp_Ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        checks++;
        if ({Rsp_Valid, Spi_Load, Spi_Enable} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b exp 000", {Rsp_Valid, Spi_Load, Spi_Enable});
        end
        checks++;
        if ({Rsp_Data, Rsp_Slave, Rsp_Error, Spi_Mode, Spi_Slave_Select, Spi_Tx_Data} !== 23'd0) begin
            errors++; $display("FAIL reset_regs: got %h exp 0",
                {Rsp_Data, Rsp_Slave, Rsp_Error, Spi_Mode, Spi_Slave_Select, Spi_Tx_Data});
        end
        checks++;
        if ({Cmd_Ready, Busy} !== 2'b10) begin
            errors++; $display("FAIL reset_ready_busy: got %b exp 10", {Cmd_Ready, Busy});
        end
        checks++;
        if (Spi_Master_Reset !== 1'b1) begin
            errors++; $display("FAIL reset_mrst_during: got %b exp 1", Spi_Master_Reset);
        end
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (Spi_Master_Reset !== 1'b1) begin
            errors++; $display("FAIL reset_mrst_after: got %b exp 1", Spi_Master_Reset);
        end
        @(negedge Clock);
        checks++;
        if (Spi_Master_Reset !== 1'b0) begin
            errors++; $display("FAIL reset_mrst_release: got %b exp 0", Spi_Master_Reset);
        end
    endtask

    task automatic test_single();
        bit ok; int ld, en, mr; rsp_t e, g;
        send(2'b01, 2'd0, 8'hA5, '{data: 8'h3C, slave: 2'b01, err: 1'b0});
        checks++;
        if (Spi_Load !== 1'b0) begin
            errors++; $display("FAIL single_load_early: got %b exp 0", Spi_Load);
        end
        @(negedge Clock);
        checks++;
        if ({Spi_Load, Spi_Tx_Data, Spi_Slave_Select, Spi_Mode} !== {1'b1, 8'hA5, 2'b01, 2'd0}) begin
            errors++; $display("FAIL single_load: got load=%b tx=%h sel=%b mode=%0d exp 1 a5 01 0",
                Spi_Load, Spi_Tx_Data, Spi_Slave_Select, Spi_Mode);
        end
        wait_rsp(100, ok, ld, en, mr);
        checks++;
        if (!ok || ld != 1 || en != 10 || mr != 0) begin
            errors++; $display("FAIL single_flow: ok=%0d loads=%0d enables=%0d mrst=%0d exp 1 1 10 0",
                ok, ld, en, mr);
        end
        e = next_exp();
        g = '{data: Rsp_Data, slave: Rsp_Slave, err: Rsp_Error};
        checks++;
        if (g !== e) begin
            errors++; $display("FAIL single_rsp: got %h/%b/%b exp %h/%b/%b",
                g.data, g.slave, g.err, e.data, e.slave, e.err);
        end
        accept();
        checks++;
        if (Rsp_Valid !== 1'b0) begin
            errors++; $display("FAIL single_rsp_drop: got %b exp 0", Rsp_Valid);
        end
    endtask

    task automatic test_invalid();
        bit ok; int ld, en, mr; rsp_t e, g;
        send(2'b00, 2'd1, 8'h55, '{data: 8'hFF, slave: 2'b00, err: 1'b1});
        wait_rsp(20, ok, ld, en, mr);
        checks++;
        if (!ok || ld != 0 || en != 0) begin
            errors++; $display("FAIL invalid_flow: ok=%0d loads=%0d enables=%0d exp 1 0 0", ok, ld, en);
        end
        e = next_exp();
        g = '{data: Rsp_Data, slave: Rsp_Slave, err: Rsp_Error};
        checks++;
        if (g !== e) begin
            errors++; $display("FAIL invalid_rsp: got %h/%b/%b exp %h/%b/%b",
                g.data, g.slave, g.err, e.data, e.slave, e.err);
        end
        accept();
    endtask

    task automatic test_timeout();
        bit ok; int ld, en, mr; rsp_t e, g;
        stub_en  = 1'b0;
        man_done = 1'b0;
        send(2'b10, 2'd2, 8'h11, '{data: 8'hFF, slave: 2'b10, err: 1'b1});
        wait_rsp(200, ok, ld, en, mr);
        checks++;
        if (!ok || ld != 1 || en != 64 || mr != 1) begin
            errors++; $display("FAIL timeout_flow: ok=%0d loads=%0d enables=%0d mrst=%0d exp 1 1 64 1",
                ok, ld, en, mr);
        end
        e = next_exp();
        g = '{data: Rsp_Data, slave: Rsp_Slave, err: Rsp_Error};
        checks++;
        if (g !== e) begin
            errors++; $display("FAIL timeout_rsp: got %h/%b/%b exp %h/%b/%b",
                g.data, g.slave, g.err, e.data, e.slave, e.err);
        end
        checks++;
        if ({Spi_Mode, Spi_Slave_Select, Spi_Tx_Data} !== {2'd2, 2'b10, 8'h11}) begin
            errors++; $display("FAIL timeout_latched: got mode=%0d sel=%b tx=%h exp 2 10 11",
                Spi_Mode, Spi_Slave_Select, Spi_Tx_Data);
        end
        accept();
        checks++;
        if ({Rsp_Valid, Spi_Master_Reset} !== 2'b00) begin
            errors++; $display("FAIL timeout_after: got valid/mrst=%b exp 00", {Rsp_Valid, Spi_Master_Reset});
        end
        stub_en = 1'b1;
    endtask

    task automatic test_backpressure();
        bit ok; int ld, en, mr, late_loads, vld; rsp_t e, g;
        logic [1:0] sl [5];
        logic [7:0] dt [5];
        sl[0] = 2'b01; sl[1] = 2'b10; sl[2] = 2'b11; sl[3] = 2'b01; sl[4] = 2'b10;
        dt[0] = 8'h10; dt[1] = 8'h21; dt[2] = 8'h32; dt[3] = 8'h43; dt[4] = 8'h54;
        Rsp_Ready = 1'b0;
        for (int k = 0; k < 5; k++)
            send(sl[k], 2'(k), dt[k], '{data: dt[k] ^ 8'h99, slave: sl[k], err: 1'b0});
        checks++;
        if (Cmd_Ready !== 1'b0) begin
            errors++; $display("FAIL bp_full: Cmd_Ready got %b exp 0", Cmd_Ready);
        end
        late_loads = 0;
        for (int i = 0; i < 30; i++) begin
            late_loads += int'(Spi_Load);
            @(negedge Clock);
        end
        vld = int'(Rsp_Valid);
        checks++;
        if (late_loads != 0 || vld != 1 || Cmd_Ready !== 1'b0) begin
            errors++; $display("FAIL bp_stall: loads=%0d valid=%0d ready=%b exp 0 1 0",
                late_loads, vld, Cmd_Ready);
        end
        for (int k = 0; k < 5; k++) begin
            wait_rsp(100, ok, ld, en, mr);
            checks++;
            if (!ok || (k > 0 && ld != 1)) begin
                errors++; $display("FAIL bp_flow_%0d: ok=%0d loads=%0d exp 1 1", k, ok, ld);
            end
            e = next_exp();
            g = '{data: Rsp_Data, slave: Rsp_Slave, err: Rsp_Error};
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL bp_rsp_%0d: got %h/%b/%b exp %h/%b/%b", k,
                    g.data, g.slave, g.err, e.data, e.slave, e.err);
            end
            accept();
            checks++;
            if (Rsp_Valid !== 1'b0) begin
                errors++; $display("FAIL bp_gap_%0d: Rsp_Valid got %b exp 0", k, Rsp_Valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        int mr, vld, ld;
        bit en_seen;
        stub_en  = 1'b0;
        man_done = 1'b0;
        send(2'b11, 2'd3, 8'h77, '{data: 8'hFF, slave: 2'b11, err: 1'b1});
        send(2'b01, 2'd0, 8'h88, '{data: 8'hFF, slave: 2'b01, err: 1'b1});
        en_seen = 1'b0;
        for (int i = 0; i < 10 && !en_seen; i++) begin
            if (Spi_Enable === 1'b1) en_seen = 1'b1;
            else @(negedge Clock);
        end
        checks++;
        if (!en_seen) begin
            errors++; $display("FAIL rmid_enable: Spi_Enable never rose, exp 1");
        end
        Reset = 1'b1;
        @(negedge Clock);
        checks++;
        if ({Spi_Enable, Busy, Cmd_Ready} !== 3'b001) begin
            errors++; $display("FAIL rmid_state: enable/busy/ready got %b exp 001", {Spi_Enable, Busy, Cmd_Ready});
        end
        Reset = 1'b0;
        exp_q.delete();
        mr = int'(Spi_Master_Reset); vld = 0; ld = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clock);
            mr  += int'(Spi_Master_Reset);
            vld += int'(Rsp_Valid);
            ld  += int'(Spi_Load);
        end
        checks++;
        if (mr != 2) begin
            errors++; $display("FAIL rmid_mrst: high cycles got %0d exp 2", mr);
        end
        checks++;
        if (vld != 0 || ld != 0 || Busy !== 1'b0) begin
            errors++; $display("FAIL rmid_silent: valid=%0d loads=%0d busy=%b exp 0 0 0", vld, ld, Busy);
        end
        stub_en = 1'b1;
    endtask

    task automatic test_stale_done();
        bit ok; int ld, en, mr, vld; rsp_t e, g;
        stub_en  = 1'b0;
        man_done = 1'b1;
        man_rx   = 8'h5E;
        repeat (2) @(negedge Clock);
        send(2'b01, 2'd1, 8'hC3, '{data: 8'h5E, slave: 2'b01, err: 1'b0});
        vld = 0;
        for (int i = 0; i < 20; i++) begin
            vld += int'(Rsp_Valid);
            @(negedge Clock);
        end
        checks++;
        if (vld != 0 || Spi_Enable !== 1'b1) begin
            errors++; $display("FAIL stale_ignored: valid=%0d enable=%b exp 0 1", vld, Spi_Enable);
        end
        man_done = 1'b0;
        repeat (2) @(negedge Clock);
        man_done = 1'b1;
        wait_rsp(10, ok, ld, en, mr);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL stale_complete: no response after fresh rising edge, exp one");
        end
        e = next_exp();
        g = '{data: Rsp_Data, slave: Rsp_Slave, err: Rsp_Error};
        checks++;
        if (g !== e) begin
            errors++; $display("FAIL stale_rsp: got %h/%b/%b exp %h/%b/%b",
                g.data, g.slave, g.err, e.data, e.slave, e.err);
        end
        accept();
        man_done = 1'b0;
        stub_en  = 1'b1;
        repeat (2) @(negedge Clock);
    endtask

`ifdef SPI_SEQ_STATS_EN
    task automatic test_stats();
        bit ok; int ld, en, mr; rsp_t e, g;
        logic [1:0] sl [4];
        logic [7:0] dt [4];
        sl[0] = 2'b01; sl[1] = 2'b00; sl[2] = 2'b10; sl[3] = 2'b11;
        dt[0] = 8'h01; dt[1] = 8'h02; dt[2] = 8'h03; dt[3] = 8'h04;
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        checks++;
        if ({Stat_Xfers, Stat_Errors} !== 32'd0) begin
            errors++; $display("FAIL stats_reset: got %h/%h exp 0/0", Stat_Xfers, Stat_Errors);
        end
        for (int k = 0; k < 4; k++) begin
            if (sl[k] == 2'b00) send(sl[k], 2'd0, dt[k], '{data: 8'hFF, slave: 2'b00, err: 1'b1});
            else                send(sl[k], 2'd0, dt[k], '{data: dt[k] ^ 8'h99, slave: sl[k], err: 1'b0});
            wait_rsp(100, ok, ld, en, mr);
            e = next_exp();
            g = '{data: Rsp_Data, slave: Rsp_Slave, err: Rsp_Error};
            checks++;
            if (!ok || g !== e) begin
                errors++; $display("FAIL stats_rsp_%0d: ok=%0d got %h/%b/%b exp %h/%b/%b", k, ok,
                    g.data, g.slave, g.err, e.data, e.slave, e.err);
            end
            accept();
        end
        checks++;
        if (Stat_Xfers !== 16'd4 || Stat_Errors !== 16'd1) begin
            errors++; $display("FAIL stats_count: got xfers=%0d errors=%0d exp 4 1", Stat_Xfers, Stat_Errors);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_invalid();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_stale_done();
`ifdef SPI_SEQ_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/spi_transaction_sequencer.md
Name: spi_transaction_sequencer

Overview:
Upstream command sequencer that drives the three-slave SPI interface top (master plus slaves I–III).
- Accepts queued byte transfers (slave, mode, tx byte) over a valid/ready port.
- Performs the load/enable/done handshake with the SPI master for each transfer, then returns the received master byte as a valid/ready response.
- Adds timeout supervision and rejection of invalid slave selects.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, ≥2)
TIMEOUT_CYCLES, 64, max cycles in WAIT_DONE before abort

Ports:
Clock  in  1  system clock; also the clock the SPI interface runs on
Reset  in  1  synchronous active-high reset
Cmd_Valid  in  1  command offered
Cmd_Ready  out  1  FIFO can accept (= !full)
Cmd_Slave  in  2  01/10/11 = slave I/II/III; 00 = invalid
Cmd_Mode  in  2  SPI mode 0–3
Cmd_Data  in  8  byte to transmit
Rsp_Valid  out  1  response available
Rsp_Ready  in  1  consumer accepts response
Rsp_Data  out  8  received byte (8'hFF on error)
Rsp_Slave  out  2  slave select of the completed command
Rsp_Error  out  1  1 = timeout or invalid slave
Busy  out  1  state != IDLE or FIFO non-empty
Spi_Master_Reset  out  1  to master reset
Spi_Load  out  1  to master parallel load strobe
Spi_Enable  out  1  to interface Enable
Spi_Mode  out  2  to interface Mode
Spi_Slave_Select  out  2  to interface Slave_Select
Spi_Tx_Data  out  8  to master parallel load data
Spi_Done  in  1  from interface done
Spi_Rx_Data  in  8  from interface master data

Behaviour:
- Reset (sync, any state):
  - FIFO flushed; state = IDLE; timeout counter = 0.
  - Rsp_Valid = 0, Rsp_Data = 0, Rsp_Slave = 0, Rsp_Error = 0.
  - Spi_Load = 0, Spi_Enable = 0, Spi_Mode = 0, Spi_Slave_Select = 0, Spi_Tx_Data = 0.
  - Spi_Master_Reset = 1 while Reset is high and for exactly 1 cycle after Reset falls.
  - Reset mid-transfer aborts silently: no response is produced.
- FIFO:
  - Push on Cmd_Valid & Cmd_Ready.
  - Pop only in IDLE when non-empty and Rsp_Valid = 0.
  - Simultaneous push and pop when not full: count unchanged.
  - Push while full is impossible because Cmd_Ready = 0; there is no bypass path.
  - Latency: a push at edge t into an empty FIFO is popped at edge t+1, and Spi_Load is high in cycle t+1..t+2.
- FSM states: IDLE, LOAD, WAIT_DONE, RESP. All SPI outputs are registered Moore outputs.
- IDLE → LOAD (Cmd_Slave != 00):
  - Latch slave, mode and data onto Spi_Slave_Select, Spi_Mode, Spi_Tx_Data.
  - These outputs hold until the next pop.
- IDLE → RESP (Cmd_Slave == 00):
  - No Spi_Load or Spi_Enable activity.
  - Rsp_Error = 1, Rsp_Data = FF, Rsp_Slave = 00.
- LOAD: Spi_Load = 1 for exactly 1 cycle; then → WAIT_DONE and clear the timeout counter.
- WAIT_DONE:
  - Spi_Enable = 1; counter increments each cycle.
  - Completion is a rising edge of Spi_Done (registered prev = 0, current = 1). A level held over from a prior transfer is ignored.
  - On the edge: capture Spi_Rx_Data into Rsp_Data, Rsp_Error = 0, → RESP.
  - If the counter reaches TIMEOUT_CYCLES−1 with no edge: Rsp_Error = 1, Rsp_Data = FF, Spi_Master_Reset pulses 1 cycle, → RESP.
  - An edge on the same cycle as the timeout counts as success.
- RESP:
  - Spi_Enable = 0; Rsp_Valid = 1, with data, slave and error held stable until Rsp_Ready.
  - On handshake: Rsp_Valid → 0 next cycle, → IDLE.
  - Back-to-back transfers therefore have at least 1 IDLE cycle between them.

Optional Feature:
SPI_SEQ_STATS_EN
- Defined:
  - Adds outputs Stat_Xfers[15:0] and Stat_Errors[15:0].
  - Both increment on each response handshake; Stat_Errors only when Rsp_Error = 1.
  - Both saturate at FFFF and clear on Reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package spi_seq_pkg:
  - state enum.
  - cmd struct {slave[1:0], mode[1:0], data[7:0]}.
  - Constants SS_NONE = 00, SS_I = 01, SS_II = 10, SS_III = 11, ERR_DATA = 8'hFF.
- Sub-module spi_cmd_fifo:
  - Parameterised by DEPTH, with synchronous Reset.
  - Ports: push/pop/full/empty.

Test Plan:
- Single transfer: push {01, mode 0, A5}; stub Spi_Done rising 10 cycles after Enable with Spi_Rx_Data = 3C.
  - Expect one Spi_Load pulse with Spi_Tx_Data = A5 and Select = 01.
  - Expect Rsp_Valid with Data = 3C, Slave = 01, Error = 0.
- Invalid slave: push {00, 1, 55}.
  - Expect no Spi_Load or Spi_Enable.
  - Expect response Error = 1, Data = FF, Slave = 00.
- Timeout: push {10, 2, 11}; Spi_Done held at 0.
  - Expect Enable high for 64 cycles, a 1-cycle Spi_Master_Reset pulse, and response Error = 1, Data = FF.
- Backpressure: push 5 commands with Rsp_Ready = 0.
  - Expect Cmd_Ready = 0 after 4 are queued plus 1 in flight.
  - Expect no second Spi_Load until the first response is accepted.
  - Expect responses in order.
- Reset mid-WAIT_DONE: assert Reset for 1 cycle.
  - Expect Enable = 0 next cycle, FIFO empty, no response, and Spi_Master_Reset high for 2 cycles.
- Stale done: Spi_Done held at 1 entering WAIT_DONE.
  - Expect no completion until it falls and rises again.
  - With SPI_SEQ_STATS_EN: after 3 good and 1 error response, Stat_Xfers = 4 and Stat_Errors = 1.
